signed_add_arbiter: RTL and testbench

Shares one registered signed two's-complement adder with overflow detection between two requesters. Each requester presents an operand pair over a valid/ready handshake. A round-robin arbiter picks one request per cycle. The registered result carries the sum, the overflow flag and the winning requester's id over a downstream valid/ready handshake. The block sits between operand producers and the consumer of signed sums, and keeps a saturating count of overflowed results for status readout.

---
 rtl/signed_add_arbiter.sv | 112 +++++++++++
 tb/tb_signed_add_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/signed_add_arbiter.sv
// Shared registered signed adder with overflow detection, fed by two requesters
// through a round-robin arbiter; keeps a saturating count of overflowed results.
module signed_add_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_overflow,
    output logic             res_id,
    output logic [CNT_W-1:0] ovf_count
);

    // Signed overflow: operands agree in sign but the truncated sum does not.
    function automatic logic add_overflow(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_sum;
    logic             r_res_overflow;
    logic             r_res_id;
    logic [CNT_W-1:0] r_ovf_count;
    logic             r_last;

    logic             w_accept_ok;
    logic             w_grant_valid;
    logic             w_grant_id;
    logic             w_transfer;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    assign w_accept_ok = !r_res_valid || res_ready;

    // Round-robin grant: a lone requester wins, a contested cycle goes to the one not served last.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = ~r_last;
        end else if (req0_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b0;
        end else if (req1_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = 1'b1;
        end else begin
            w_grant_valid = 1'b0;
            w_grant_id    = 1'b0;
        end
    end

    // Ready is forced low while reset is asserted so a pending pair is not consumed.
    assign w_transfer = rst_n && w_accept_ok && w_grant_valid;
    assign req0_ready = w_transfer && (w_grant_id == 1'b0);
    assign req1_ready = w_transfer && (w_grant_id == 1'b1);

    assign w_a   = w_grant_id ? req1_a : req0_a;
    assign w_b   = w_grant_id ? req1_b : req0_b;
    assign w_sum = w_a + w_b;
    assign w_ovf = add_overflow(w_a, w_b, w_sum);

    // Result register, round-robin pointer and saturating overflow counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_valid    <= 1'b0;
            r_res_sum      <= {WIDTH{1'b0}};
            r_res_overflow <= 1'b0;
            r_res_id       <= 1'b0;
            r_ovf_count    <= {CNT_W{1'b0}};
            r_last         <= 1'b1;
        end else if (w_transfer) begin
            r_res_valid    <= 1'b1;
            r_res_sum      <= w_sum;
            r_res_overflow <= w_ovf;
            r_res_id       <= w_grant_id;
            r_last         <= w_grant_id;
            if (w_ovf && (r_ovf_count != {CNT_W{1'b1}})) begin
                r_ovf_count <= r_ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_ovf_count <= r_ovf_count;
            end
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= r_res_valid;
        end
    end

    assign res_valid    = r_res_valid;
    assign res_sum      = r_res_sum;
    assign res_overflow = r_res_overflow;
    assign res_id       = r_res_id;
    assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Self-checking bench for signed_add_arbiter: directed protocol steps followed by
// randomized traffic, compared against an integer-arithmetic reference model.
module tb_signed_add_arbiter;
    localparam int W  = 4;
    localparam int CW = 2;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic          res_valid, res_ready, res_overflow, res_id;
    logic [W-1:0]  res_sum;
    logic [CW-1:0] ovf_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_valid;
    int m_sum, m_ovf, m_id, m_cnt, m_last, m_xfer;
    int served0, served1;

    always #5 clk = ~clk;

    signed_add_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_overflow(res_overflow), .res_id(res_id), .ovf_count(ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_sum = 0; m_ovf = 0; m_id = 0; m_cnt = 0; m_last = 1;
    endtask

    task automatic drive(input bit v0, input int a0, input int b0,
                         input bit v1, input int a1, input int b1, input bit rr);
        req0_valid = v0; req0_a = W'(a0); req0_b = W'(b0);
        req1_valid = v1; req1_a = W'(a1); req1_b = W'(b1);
        res_ready  = rr;
    endtask

    // One clock: check handshake readies, advance the model, check registered outputs.
    task automatic cycle();
        int g, a, b, s;
        bit acc, e0, e1;
        #1;
        e0 = 1'b0; e1 = 1'b0;
        if (rst_n) begin
            acc = !m_valid || res_ready;
            if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
            else                          g = -1;
            e0 = acc && (g == 0);
            e1 = acc && (g == 1);
        end
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        m_xfer = -1;
        if (!rst_n) begin
            model_reset();
        end else if (e0 || e1) begin
            a = e1 ? int'($signed(req1_a)) : int'($signed(req0_a));
            b = e1 ? int'($signed(req1_b)) : int'($signed(req0_b));
            s = a + b;
            m_sum   = s & ((1 << W) - 1);
            m_ovf   = (s > SMAX || s < SMIN) ? 1 : 0;
            m_id    = e1 ? 1 : 0;
            m_valid = 1'b1;
            m_last  = m_id;
            m_xfer  = m_id;
            if (m_ovf == 1 && m_cnt < CMAX) m_cnt++;
            if (e1) served1++; else served0++;
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("res_valid",    {31'd0, res_valid},    {31'd0, m_valid});
        chk("res_sum",      {28'd0, res_sum},      32'(m_sum));
        chk("res_overflow", {31'd0, res_overflow}, 32'(m_ovf));
        chk("res_id",       {31'd0, res_id},       32'(m_id));
        chk("ovf_count",    {30'd0, ovf_count},    32'(m_cnt));
    endtask

    initial begin
        int sat_exp [5];
        int ra0, rb0, ra1, rb1;
        sat_exp = '{1, 2, 3, 3, 3};
        model_reset();
        served0 = 0; served1 = 0;

        // Reset held two cycles with both requesters valid
        rst_n = 1'b0;
        drive(1'b1, 1, 2, 1'b1, 3, 4, 1'b1);
        cycle();
        cycle();
        chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
        chk("reset_ovf_count", {30'd0, ovf_count}, 32'd0);

        // First contested cycle after release goes to requester 0
        rst_n = 1'b1;
        cycle();
        chk("first_grant_id", {31'd0, res_id}, 32'd0);

        // Single requester streaming with boundary pairs
        drive(1'b1, 7, 1, 1'b0, 0, 0, 1'b1);   cycle();
        chk("stream0_sum", {28'd0, res_sum}, 32'h8);
        drive(1'b1, 3, -5, 1'b0, 0, 0, 1'b1);  cycle();
        chk("stream1_sum", {28'd0, res_sum}, 32'he);
        drive(1'b1, -8, -1, 1'b0, 0, 0, 1'b1); cycle();
        chk("stream2_sum", {28'd0, res_sum}, 32'h7);
        chk("stream_ovf_count", {30'd0, ovf_count}, 32'd2);
        drive(1'b1, -8, 7, 1'b0, 0, 0, 1'b1);  cycle();
        chk("bound_m8p7_sum", {28'd0, res_sum}, 32'hf);

        // Round-robin fairness with both requesters always valid
        served0 = 0; served1 = 0;
        ra0 = $urandom_range(0, 15); rb0 = $urandom_range(0, 15);
        ra1 = $urandom_range(0, 15); rb1 = $urandom_range(0, 15);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ra0, rb0, 1'b1, ra1, rb1, 1'b1);
            cycle();
            if (m_xfer == 0) begin ra0 = $urandom_range(0, 15); rb0 = $urandom_range(0, 15); end
            if (m_xfer == 1) begin ra1 = $urandom_range(0, 15); rb1 = $urandom_range(0, 15); end
        end
        chk("fair_served0", 32'(served0), 32'd3);
        chk("fair_served1", 32'(served1), 32'd3);

        // Backpressure: result stays stable while the consumer stalls
        drive(1'b1, -4, -4, 1'b0, 0, 0, 1'b1); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 0, 1'b1, 2, 3, 1'b0);
            cycle();
            chk("bp_hold_sum", {28'd0, res_sum}, 32'h8);
            chk("bp_hold_ovf", {31'd0, res_overflow}, 32'd0);
        end
        drive(1'b0, 0, 0, 1'b1, 2, 3, 1'b1); cycle();
        chk("bp_release_sum", {28'd0, res_sum}, 32'h5);
        chk("bp_release_id",  {31'd0, res_id},  32'd1);

        // Reset mid-stream while a result is held
        drive(1'b1, 1, 1, 1'b1, 2, 2, 1'b0); cycle();
        rst_n = 1'b0; cycle();
        chk("midrst_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_count", {30'd0, ovf_count}, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1, 1, 1'b1, 2, 2, 1'b1); cycle();
        chk("midrst_grant", {31'd0, res_id}, 32'd0);

        // Counter saturation on repeated overflow
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 7, 7, 1'b0, 0, 0, 1'b1);
            cycle();
            chk("sat_count", {30'd0, ovf_count}, 32'(sat_exp[i]));
        end

        // Randomized traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                  1'($urandom_range(0, 3) != 0));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
